spi_bus_scheduler: RTL and testbench

Shared SPI master that schedules serial transfers from up to NREQ on-board requesters, such as DAC update, auxiliary ADC and expansion devices, onto one physical SCLK/MOSI/MISO bus. Each requester has its own active-low chip select. Arbitration is round-robin. Each granted requester gets one complete transfer of 1..32 bits in SPI mode 0, and the data read back is returned with a done pulse. The block runs on sysclk (49.152 MHz) alongside the FireWire register datapath.

---
 rtl/spi_bus_scheduler.sv | 210 +++++++++++++++++++++
 tb/tb_spi_bus_scheduler.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_bus_scheduler.sv
// Shared SPI mode-0 master: round-robin arbitration between NREQ requesters,
// one transfer of 1..32 bits per grant, read data returned with a done pulse.
module spi_bus_scheduler #(
  parameter int NREQ    = 4,
  parameter int CLKDIV  = 2,
  parameter int CS_HOLD = 2
) (
  input  logic                 sysclk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*32-1:0]   req_wdata,
  input  logic [NREQ*6-1:0]    req_len,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      done,
  output logic [31:0]          rdata,
  output logic                 busy,
  output logic                 sclk,
  output logic                 mosi,
  input  logic                 miso,
  output logic [NREQ-1:0]      csn
);

  localparam int IW = $clog2(NREQ);
  localparam logic [15:0] DIV_LAST  = 16'(CLKDIV - 1);
  localparam logic [15:0] HOLD_LAST = 16'(CS_HOLD - 1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   last_q, last_d;
  logic [5:0]      len_q, len_d;
  logic [5:0]      bit_q, bit_d;
  logic [31:0]     tx_q, tx_d;
  logic [31:0]     rx_q, rx_d;
  logic [31:0]     rdata_q, rdata_d;
  logic [15:0]     div_q, div_d;
  logic            sclk_q, sclk_d;
  logic            mosi_q, mosi_d;
  logic            busy_q, busy_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] done_q, done_d;
  logic [NREQ-1:0] csn_q, csn_d;

  logic [31:0]     wdata_arr [NREQ];
  logic [5:0]      len_arr   [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_slice
      assign wdata_arr[gi] = req_wdata[32*gi +: 32];
      assign len_arr[gi]   = req_len[6*gi +: 6];
    end
  endgenerate

  // Round-robin pick: first set req bit starting just after the last winner.
  logic            found;
  logic [IW-1:0]   pick;
  int              sum;
  logic [5:0]      pick_len_raw;
  logic [5:0]      pick_len;
  logic [31:0]     pick_tx;

  always_comb begin
    found = 1'b0;
    pick  = '0;
    sum   = 0;
    for (int k = 1; k <= NREQ; k++) begin
      sum = int'(last_q) + k;
      if (sum >= NREQ) sum = sum - NREQ;
      if (!found && req[sum[IW-1:0]]) begin
        found = 1'b1;
        pick  = sum[IW-1:0];
      end
    end
    pick_len_raw = len_arr[pick];
    pick_len     = (pick_len_raw == 6'd0 || pick_len_raw > 6'd32) ? 6'd32 : pick_len_raw;
    // Left-align the word so the current MOSI bit is always tx[31].
    pick_tx      = wdata_arr[pick] << (6'd32 - pick_len);
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    len_d   = len_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    rdata_d = rdata_q;
    div_d   = div_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    csn_d   = csn_q;

    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d     = S_SETUP;
          last_d      = pick;
          len_d       = pick_len;
          tx_d        = pick_tx;
          mosi_d      = pick_tx[31];
          rx_d        = '0;
          bit_d       = '0;
          div_d       = '0;
          sclk_d      = 1'b0;
          gnt_d       = '0;
          gnt_d[pick] = 1'b1;
          csn_d       = '1;
          csn_d[pick] = 1'b0;
        end
      end

      S_SETUP: begin
        if (div_q == DIV_LAST) begin
          state_d = S_SHIFT;
          div_d   = '0;
          sclk_d  = 1'b1;
          rx_d    = {rx_q[30:0], miso};
        end else begin
          div_d = div_q + 16'd1;
        end
      end

      S_SHIFT: begin
        if (div_q != DIV_LAST) begin
          div_d = div_q + 16'd1;
        end else if (sclk_q) begin
          div_d  = '0;
          sclk_d = 1'b0;
          tx_d   = tx_q << 1;
          mosi_d = (bit_q == len_q - 6'd1) ? 1'b0 : tx_q[30];
        end else if (bit_q == len_q - 6'd1) begin
          state_d = S_HOLD;
          div_d   = '0;
        end else begin
          div_d  = '0;
          bit_d  = bit_q + 6'd1;
          sclk_d = 1'b1;
          rx_d   = {rx_q[30:0], miso};
        end
      end

      S_HOLD: begin
        if (div_q == HOLD_LAST) begin
          state_d = S_DONE;
          csn_d   = '1;
          done_d  = gnt_q;
          // rx started at zero and shifted len times, so it is right-aligned.
          rdata_d = rx_q;
        end else begin
          div_d = div_q + 16'd1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        gnt_d   = '0;
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge sysclk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      last_q  <= IW'(NREQ - 1);
      len_q   <= '0;
      bit_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      rdata_q <= '0;
      div_q   <= '0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      gnt_q   <= '0;
      done_q  <= '0;
      csn_q   <= '1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      len_q   <= len_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      rdata_q <= rdata_d;
      div_q   <= div_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      busy_q  <= busy_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      csn_q   <= csn_d;
    end
  end

  assign gnt   = gnt_q;
  assign done  = done_q;
  assign rdata = rdata_q;
  assign busy  = busy_q;
  assign sclk  = sclk_q;
  assign mosi  = mosi_q;
  assign csn   = csn_q;

endmodule

// File: tb/tb_spi_bus_scheduler.sv
// Bench for spi_bus_scheduler: directed transfers, expectations queued at issue
// time and checked by an independent monitor on every done pulse.
module tb_spi_bus_scheduler;

  localparam int NREQ    = 4;
  localparam int CLKDIV  = 2;
  localparam int CS_HOLD = 2;

  logic                sysclk = 1'b0;
  logic                reset;
  logic [NREQ-1:0]     req;
  logic [NREQ*32-1:0]  req_wdata;
  logic [NREQ*6-1:0]   req_len;
  logic [NREQ-1:0]     gnt, done, csn;
  logic [31:0]         rdata;
  logic                busy, sclk, mosi, miso;
  logic [1:0]          miso_mode;   // 0 loopback, 1 tied high, 2 tied low
  logic [31:0]         wd [NREQ];
  logic [5:0]          ln [NREQ];

  always #10 sysclk = ~sysclk;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_pack
      assign req_wdata[32*gi +: 32] = wd[gi];
      assign req_len[6*gi +: 6]     = ln[gi];
    end
  endgenerate

  assign miso = (miso_mode == 2'd0) ? mosi : (miso_mode == 2'd1);

  spi_bus_scheduler #(.NREQ(NREQ), .CLKDIV(CLKDIV), .CS_HOLD(CS_HOLD)) dut (
    .sysclk(sysclk), .reset(reset), .req(req), .req_wdata(req_wdata),
    .req_len(req_len), .gnt(gnt), .done(done), .rdata(rdata), .busy(busy),
    .sclk(sclk), .mosi(mosi), .miso(miso), .csn(csn)
  );

  typedef struct {
    int          idx;
    logic [31:0] rdata;
    int          len;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge sysclk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input int idx, input logic [31:0] rd, input int len);
    exp_t e;
    e.idx = idx; e.rdata = rd; e.len = len;
    exp_q.push_back(e);
  endtask

  // Monitor: tracks grant start and SCLK pulses, checks every done against the queue.
  logic [NREQ-1:0] prev_gnt = '0;
  logic            prev_sclk = 1'b0;
  int              gnt_start = 0;
  int              sclk_cnt = 0;
  exp_t            mon_e;

  always @(negedge sysclk) begin
    if (gnt != '0 && prev_gnt == '0) begin
      gnt_start = cyc;
      sclk_cnt  = 0;
    end
    if (sclk && !prev_sclk) sclk_cnt++;
    if (reset && csn != '1) begin
      checks++;
      if ($countones(~csn) != 1 || (~csn & ~gnt) != '0) begin
        errors++;
        $display("FAIL csn_excl: csn=%b gnt=%b required one low csn inside gnt", csn, gnt);
      end
    end
    if (done != '0) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: done=%b required no done", done);
      end else begin
        mon_e = exp_q.pop_front();
        chk("done_vec", 32'(done), 32'(1) << mon_e.idx);
        chk("gnt_at_done", 32'(gnt), 32'(1) << mon_e.idx);
        chk("rdata", rdata, mon_e.rdata);
        chk("latency", 32'(cyc - gnt_start), 32'(CLKDIV + 2*CLKDIV*mon_e.len + CS_HOLD));
        chk("sclk_pulses", 32'(sclk_cnt), 32'(mon_e.len));
        $display("done req %0d rdata 0x%08h sclk %0d grant-to-done %0d", mon_e.idx, rdata, sclk_cnt, cyc - gnt_start);
      end
    end
    prev_gnt  = gnt;
    prev_sclk = sclk;
  end

  task automatic wait_gnt(input int idx);
    int   n = 0;
    logic p = gnt[idx];
    while (!(gnt[idx] && !p) && n < 500) begin
      p = gnt[idx];
      @(negedge sysclk);
      n++;
    end
    checks++;
    if (n >= 500) begin
      errors++;
      $display("FAIL wait_gnt: grant %0d not seen within 500 cycles, gnt=%b", idx, gnt);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 3000) begin
      @(negedge sysclk);
      n++;
    end
    checks++;
    if (n >= 3000) begin
      errors++;
      $display("FAIL wait_idle: %0d transfers outstanding, busy=%b, required idle", exp_q.size(), busy);
      exp_q.delete();
    end
  endtask

  task automatic pulse_req(input logic [NREQ-1:0] m);
    req = m;
    @(negedge sysclk);
    req = '0;
  endtask

  initial begin
    int   rises;
    int   n;
    logic p;

    reset = 1'b0; req = '0; miso_mode = 2'd0;
    for (int i = 0; i < NREQ; i++) begin wd[i] = '0; ln[i] = '0; end
    repeat (3) @(negedge sysclk);
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_sclk", 32'(sclk), 32'h0);
    chk("rst_mosi", 32'(mosi), 32'h0);
    chk("rst_csn", 32'(csn), 32'hF);
    reset = 1'b1;
    @(negedge sysclk);

    // All four requesting continuously: 0,1,2,3 then 0 again.
    wd[0] = 32'h11223344; wd[1] = 32'h55667788; wd[2] = 32'h99AABBCC; wd[3] = 32'hDDEEFF01;
    for (int i = 0; i < NREQ; i++) ln[i] = 6'd8;
    push_exp(0, 32'h44, 8); push_exp(1, 32'h88, 8); push_exp(2, 32'hCC, 8);
    push_exp(3, 32'h01, 8); push_exp(0, 32'h44, 8);
    req = 4'b1111;
    wait_gnt(0); wait_gnt(1); wait_gnt(2); wait_gnt(3); wait_gnt(0);
    req = '0;
    wait_idle();

    // Single 16-bit loopback transfer; grant visible one cycle after the latch.
    wd[0] = 32'h0000A5C3; ln[0] = 6'd16;
    push_exp(0, 32'h0000A5C3, 16);
    req = 4'b0001;
    @(negedge sysclk);
    chk("gnt_cycle1", 32'(gnt), 32'h1);
    chk("csn_cycle1", 32'(csn), 32'hE);
    chk("busy_cycle1", 32'(busy), 32'h1);
    req = '0;
    wait_idle();

    // Length 0 and 40 both mean 32 bits.
    wd[0] = 32'hDEADBEEF; ln[0] = 6'd0;
    push_exp(0, 32'hDEADBEEF, 32);
    pulse_req(4'b0001);
    wait_idle();
    ln[0] = 6'd40;
    push_exp(0, 32'hDEADBEEF, 32);
    pulse_req(4'b0001);
    wait_idle();

    // MISO tied high / low, and the 1-bit boundary.
    miso_mode = 2'd1; wd[0] = 32'h0; ln[0] = 6'd5;
    push_exp(0, 32'h0000001F, 5);
    pulse_req(4'b0001);
    wait_idle();
    miso_mode = 2'd2; wd[0] = 32'hFFFFFFFF;
    push_exp(0, 32'h0, 5);
    pulse_req(4'b0001);
    wait_idle();
    miso_mode = 2'd0; wd[0] = 32'h1; ln[0] = 6'd1;
    push_exp(0, 32'h1, 1);
    pulse_req(4'b0001);
    wait_idle();

    // Reset during bit 10 of a 24-bit transfer: no done, bus released at once.
    wd[0] = 32'h00ABCDEF; ln[0] = 6'd24;
    req = 4'b0001;
    rises = 0; n = 0; p = sclk;
    while (rises < 11 && n < 500) begin
      @(negedge sysclk);
      if (sclk && !p) rises++;
      p = sclk;
      n++;
    end
    checks++;
    if (n >= 500) begin
      errors++;
      $display("FAIL abort_wait: saw %0d SCLK rises, required 11", rises);
    end
    reset = 1'b0; req = '0;
    @(negedge sysclk);
    chk("abort_csn", 32'(csn), 32'hF);
    chk("abort_sclk", 32'(sclk), 32'h0);
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_gnt", 32'(gnt), 32'h0);
    chk("abort_done", 32'(done), 32'h0);
    chk("abort_rdata", rdata, 32'h0);
    reset = 1'b1;
    repeat (10) @(negedge sysclk);
    wd[0] = 32'h12345678; ln[0] = 6'd12;
    wd[1] = 32'h0000BEEF; ln[1] = 6'd16;
    push_exp(0, 32'h00000678, 12);
    push_exp(1, 32'h0000BEEF, 16);
    req = 4'b0011;
    wait_gnt(0);
    req = 4'b0010;
    wait_gnt(1);
    req = '0;
    wait_idle();

    // One-cycle request still completes once, with no regrant.
    wd[2] = 32'h0000005A; ln[2] = 6'd7;
    push_exp(2, 32'h0000005A, 7);
    pulse_req(4'b0100);
    chk("short_req_gnt", 32'(gnt), 32'h4);
    wait_idle();
    repeat (40) @(negedge sysclk);
    chk("no_regrant_gnt", 32'(gnt), 32'h0);
    chk("no_regrant_busy", 32'(busy), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
